// File: rtl/alu8_sequencer.sv
// Request/response front-end for an external 8-bit combinational ALU.
// Registers operands, waits a fixed settle time, captures result and flags.
module alu8_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_a,
   input  logic [7:0]       req_b,
   input  logic [2:0]       req_op,
   input  logic             req_chain,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_op,
   input  logic [7:0]       alu_z,
   input  logic             alu_cout,
   input  logic             alu_ov,
   input  logic             alu_sign,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_z,
   output logic [3:0]       rsp_flags,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [7:0]       acc_q, acc_d;
   logic [7:0]       z_q, z_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] ops_q, ops_d;

   logic accept, capture, done;

   assign accept  = (state_q == IDLE) && req_valid;
   assign capture = (state_q == EXEC) && (cnt_q == 4'd0);
   assign done    = (state_q == RESP) && rsp_ready;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         op_q    <= 3'd0;
         acc_q   <= 8'h00;
         z_q     <= 8'h00;
         flags_q <= 4'h0;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         flags_q <= flags_d;
         ops_q   <= ops_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = EXEC;
         EXEC:    if (cnt_q == 4'd0) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values; ALU inputs hold until the next accept
   always_comb begin
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      z_d     = z_q;
      flags_d = flags_q;
      ops_d   = ops_q;
      if (accept) begin
         a_d   = req_chain ? acc_q : req_a;
         b_d   = req_b;
         op_d  = req_op;
         cnt_d = SETTLE_LD;
      end
      if ((state_q == EXEC) && (cnt_q != 4'd0))
         cnt_d = cnt_q - 4'd1;
      if (capture) begin
         z_d     = alu_z;
         flags_d = {alu_ov, alu_cout, alu_sign, (alu_z == 8'h00)};
         acc_d   = alu_z;
      end
      if (done && (ops_q != {CNT_W{1'b1}}))
         ops_d = ops_q + 1'b1;
   end

   // Outputs
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign rsp_z     = z_q;
   assign rsp_flags = flags_q;
   assign op_count  = ops_q;

endmodule

// File: tb/tb_alu8_sequencer.sv
// Bench for alu8_sequencer: two instances (settle 1 and 3) driven by an ALU
// model, checked against an operation-level model of results and timing.
module tb_alu8_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic [7:0]  req_a     [2];
   logic [7:0]  req_b     [2];
   logic [2:0]  req_op    [2];
   logic        req_chain [2];
   logic [7:0]  alu_a     [2];
   logic [7:0]  alu_b     [2];
   logic [2:0]  alu_op    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [7:0]  rsp_z     [2];
   logic [3:0]  rsp_flags [2];
   logic [15:0] op_count  [2];

   int vecs = 0;
   int errs = 0;

   logic [7:0]  acc_m [2];
   logic [15:0] cnt_m [2];

   // {ov, cout, z}: signed-range overflow, unsigned carry / borrow
   function automatic logic [9:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] op);
      int sa, sb, r;
      logic [8:0] u;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         3'd0: begin
            u = {1'b0, a} + {1'b0, b};
            r = sa + sb;
            return {(r > 127 || r < -128), u[8], u[7:0]};
         end
         3'd1: begin
            r = sa - sb;
            return {(r > 127 || r < -128), (a < b), 8'(a - b)};
         end
         3'd2:    return {2'b00, a & b};
         3'd3:    return {2'b00, a | b};
         3'd4:    return {2'b00, a ^ b};
         3'd5:    return {2'b00, ~a};
         3'd6:    return {2'b00, a >> 1};
         default: return {2'b00, a << 1};
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [9:0] alu_r;
      assign alu_r = alu_f(alu_a[g], alu_b[g], alu_op[g]);
      alu8_sequencer #(.SETTLE_CYCLES(g == 0 ? 1 : 3), .CNT_W(16)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n[g]),
         .req_valid(req_valid[g]),
         .req_ready(req_ready[g]),
         .req_a    (req_a[g]),
         .req_b    (req_b[g]),
         .req_op   (req_op[g]),
         .req_chain(req_chain[g]),
         .alu_a    (alu_a[g]),
         .alu_b    (alu_b[g]),
         .alu_op   (alu_op[g]),
         .alu_z    (alu_r[7:0]),
         .alu_cout (alu_r[8]),
         .alu_ov   (alu_r[9]),
         .alu_sign (alu_r[7]),
         .rsp_valid(rsp_valid[g]),
         .rsp_ready(rsp_ready[g]),
         .rsp_z    (rsp_z[g]),
         .rsp_flags(rsp_flags[g]),
         .op_count (op_count[g])
      );
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(int d);
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_alu_a", 32'(alu_a[d]), 32'd0);
      chk("rst_alu_b", 32'(alu_b[d]), 32'd0);
      chk("rst_alu_op", 32'(alu_op[d]), 32'd0);
      chk("rst_rsp_z", 32'(rsp_z[d]), 32'd0);
      chk("rst_flags", 32'(rsp_flags[d]), 32'd0);
      chk("rst_op_count", 32'(op_count[d]), 32'd0);
   endtask

   // One full transaction; called at a negedge with the DUT idle
   task automatic do_op(int d, logic [7:0] a, logic [7:0] b, logic [2:0] op,
                        logic chain, int stall);
      int st;
      logic [7:0] a_eff, exp_z;
      logic [3:0] exp_f;
      logic [9:0] r;
      st    = (d == 0) ? 1 : 3;
      a_eff = chain ? acc_m[d] : a;
      r     = alu_f(a_eff, b, op);
      exp_z = r[7:0];
      exp_f = {r[9], r[8], r[7], (r[7:0] == 8'h00)};
      chk("idle_ready", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_a[d] = a; req_b[d] = b; req_op[d] = op; req_chain[d] = chain;
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_a[d] = 8'($urandom); req_b[d] = 8'($urandom);
      req_op[d] = 3'($urandom); req_chain[d] = 1'($urandom);
      rsp_ready[d] = 1'($urandom);
      for (int k = 0; k < st; k++) begin
         if (k > 0) begin
            @(posedge clk);
            @(negedge clk);
         end
         chk("exec_valid", 32'(rsp_valid[d]), 32'd0);
         chk("exec_ready", 32'(req_ready[d]), 32'd0);
         chk("exec_alu_a", 32'(alu_a[d]), 32'(a_eff));
         chk("exec_alu_b", 32'(alu_b[d]), 32'(b));
         chk("exec_alu_op", 32'(alu_op[d]), 32'(op));
      end
      rsp_ready[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      acc_m[d] = exp_z;
      chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
      chk("rsp_z", 32'(rsp_z[d]), 32'(exp_z));
      chk("rsp_flags", 32'(rsp_flags[d]), 32'(exp_f));
      for (int s = 0; s < stall; s++) begin
         req_valid[d] = 1'b1;
         req_a[d] = 8'($urandom); req_b[d] = 8'($urandom);
         req_op[d] = 3'($urandom); req_chain[d] = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("stall_valid", 32'(rsp_valid[d]), 32'd1);
         chk("stall_ready", 32'(req_ready[d]), 32'd0);
         chk("stall_z", 32'(rsp_z[d]), 32'(exp_z));
         chk("stall_alu_a", 32'(alu_a[d]), 32'(a_eff));
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      if (cnt_m[d] != 16'hFFFF) cnt_m[d]++;
      chk("done_valid", 32'(rsp_valid[d]), 32'd0);
      chk("done_ready", 32'(req_ready[d]), 32'd1);
      chk("op_count", 32'(op_count[d]), 32'(cnt_m[d]));
      chk("hold_alu_a", 32'(alu_a[d]), 32'(a_eff));
   endtask

   task automatic reset_mid(int d);
      req_valid[d] = 1'b1;
      req_a[d] = 8'h33; req_b[d] = 8'h44; req_op[d] = 3'd0; req_chain[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      rst_n[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n[d] = 1'b1;
      acc_m[d] = 8'h00;
      cnt_m[d] = 16'h0000;
      check_reset(d);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
         req_a[d] = 8'h00; req_b[d] = 8'h00; req_op[d] = 3'd0; req_chain[d] = 1'b0;
         acc_m[d] = 8'h00; cnt_m[d] = 16'h0000;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      check_reset(0);
      check_reset(1);

      // settle = 1
      do_op(0, 8'h7F, 8'h01, 3'd0, 1'b0, 0);
      chk("tp1_z", 32'(rsp_z[0]), 32'h80);
      chk("tp1_flags", 32'(rsp_flags[0]), 32'hA);
      chk("tp1_count", 32'(op_count[0]), 32'd1);
      do_op(0, 8'h00, 8'h01, 3'd1, 1'b0, 0);
      chk("tp2a_z", 32'(rsp_z[0]), 32'hFF);
      chk("tp2a_flags", 32'(rsp_flags[0]), 32'h6);
      do_op(0, 8'h10, 8'h10, 3'd1, 1'b0, 0);
      chk("tp2b_z", 32'(rsp_z[0]), 32'h00);
      chk("tp2b_flags", 32'(rsp_flags[0]), 32'h1);
      do_op(0, 8'h03, 8'h04, 3'd0, 1'b0, 0);
      chk("tp3a_z", 32'(rsp_z[0]), 32'h07);
      do_op(0, 8'hAA, 8'h05, 3'd0, 1'b1, 0);
      chk("tp3b_z", 32'(rsp_z[0]), 32'h0C);
      chk("tp3b_alu_a", 32'(alu_a[0]), 32'h07);
      do_op(0, 8'h55, 8'h22, 3'd4, 1'b0, 5);
      chk("tp4_z", 32'(rsp_z[0]), 32'h77);
      for (int i = 0; i < 20; i++)
         do_op(0, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)));
      reset_mid(0);
      do_op(0, 8'hAA, 8'h05, 3'd0, 1'b1, 0);
      chk("tp6_chain_z", 32'(rsp_z[0]), 32'h05);

      // settle = 3
      do_op(1, 8'hF0, 8'h0F, 3'd3, 1'b0, 0);
      chk("tp5_z", 32'(rsp_z[1]), 32'hFF);
      chk("tp5_flags", 32'(rsp_flags[1]), 32'h2);
      for (int i = 0; i < 12; i++)
         do_op(1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)));
      reset_mid(1);
      do_op(1, 8'h99, 8'h01, 3'd0, 1'b1, 1);
      chk("tp6b_chain_z", 32'(rsp_z[1]), 32'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
